wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
Writeback stage of the RV32I core, directly upstream of the register file's write port. It accepts one completed instruction per handshake from the memory stage. For loads it waits for the data-memory response, then byte/halfword-aligns and sign/zero-extends the data. It drives the register-file write port and a forwarding tap for the hazard logic, and keeps a retired-instruction counter.

Parameters:
XLEN, 32, datapath width
REG_ADDR_W, 5, register address width
LOAD_TIMEOUT, 16, cycles to wait for a load response before flagging an error (≥2)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous reset, active-low (rst=0 resets)
in_valid  input  1  upstream holds a completed instruction
in_ready  output  1  stage can accept this cycle
in_reg_write  input  1  instruction writes rd
in_is_load  input  1  instruction is a load
in_rd  input  REG_ADDR_W  destination register
in_result  input  XLEN  ALU result; for loads, the effective address
in_funct3  input  3  load width/sign code
dmem_rvalid  input  1  load data valid, single-cycle pulse
dmem_rdata  input  XLEN  aligned word read from data memory
rf_we  output  1  register-file write enable
rf_waddr  output  REG_ADDR_W  register-file write address
rf_wdata  output  XLEN  register-file write data
fwd_valid  output  1  rf_we is valid for forwarding this cycle
load_err  output  1  one-cycle pulse: misaligned, illegal funct3, or timeout
retired  output  32  count of committed instructions, wraps

Behaviour:
- Reset values (async on rst=0, for the whole duration of reset): state=IDLE; rf_we=0; rf_waddr=0; rf_wdata=0; fwd_valid=0; load_err=0; retired=0; timeout counter=0.
- FSM states: IDLE, WAIT, WRITE. in_ready=1 in IDLE and WRITE, 0 in WAIT. Accept = in_valid & in_ready.
- Accept of a non-load: latch rd, result and reg_write, then go to WRITE.
- Accept of a load:
  - Check alignment on in_result[1:0].
  - LW needs 00. LH/LHU need bit0=0. LB/LBU accept any offset.
  - funct3 ∉ {000,001,010,100,101} is illegal.
  - Misaligned or illegal: pulse load_err next cycle, no write, no retire count, go to IDLE (or WRITE if a back-to-back accept occurs). Upstream does not issue the memory access in this case.
  - Otherwise: latch rd, offset and funct3, clear the timeout counter, go to WAIT.
- WAIT:
  - dmem_rvalid=1: extract data, go to WRITE. The byte is rdata[8*off+7:8*off]; the halfword is rdata[16*off[1]+15:16*off[1]]. Sign-extend for LB/LH, zero-extend for LBU/LHU; LW passes the word through.
  - Otherwise increment the counter. On reaching LOAD_TIMEOUT: pulse load_err, no write, go to IDLE.
- WRITE (one cycle):
  - rf_we = latched reg_write & (rd≠0).
  - rf_waddr / rf_wdata hold the latched values; fwd_valid = rf_we.
  - retired increments by 1, including rd=0 and reg_write=0 instructions.
  - A new accept in WRITE goes to WRITE (non-load) or WAIT (load) with no bubble; otherwise go to IDLE.
- Outputs are registered. rf_we is 0 in every cycle not in WRITE. rf_waddr/rf_wdata hold their last values when rf_we=0.
- dmem_rvalid outside WAIT is ignored. A response arriving after a timeout or a reset is discarded.
- Simultaneous load_err and a new accept: both proceed; load_err is independent of the next instruction.
- Reset mid-WAIT or mid-WRITE aborts the instruction with no write. retired returns to 0.
- Throughput: 1 instr/cycle for ALU ops. A load takes ≥2 cycles from accept to write.

Test Plan:
1. Reset with rst=0 mid-WAIT, then release → all outputs 0 and state IDLE. A following dmem_rvalid produces no write.
2. Three back-to-back ALU ops (rd=1,2,0; results 0xA, 0xB, 0xC) → rf_we in 3 consecutive cycles as 1,1,0; waddr 1,2; wdata 0xA, 0xB; retired=3.
3. LB at address 0x103, rdata=0x80FF_1234 → write 0xFFFF_FF80. LBU, same address and data → 0x0000_0080. LH at 0x102, same data → 0xFFFF_80FF.
4. LW at address 0x2, then funct3=011 at address 0x0 → two load_err pulses, no rf_we, retired unchanged, in_ready stays 1.
5. Load accepted with no dmem_rvalid for LOAD_TIMEOUT cycles → load_err pulse, return to IDLE. A late dmem_rvalid is ignored and rf_we stays 0.
6. Load with rd=5 whose dmem_rvalid coincides with in_valid of an ALU op (rd=6) → in_ready=0 that cycle. The ALU op is accepted in the WRITE cycle; writes to x5 then x6 occur on consecutive cycles.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: takes one completed instruction from the memory stage,
// waits for the data-memory response on loads, aligns and extends load data,
// and drives the register-file write port plus a forwarding tap. It also
// counts retired instructions.
//
// Handshake: an instruction transfers on a rising edge where in_valid and
// in_ready are both 1. Upstream holds all in_* fields stable while in_valid=1
// and in_ready=0. in_ready is 0 only while waiting for load data.
module wb_stage #(
    parameter int XLEN         = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int LOAD_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_reg_write,
    input  logic                  in_is_load,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [XLEN-1:0]       in_result,
    input  logic [2:0]            in_funct3,
    input  logic                  dmem_rvalid,
    input  logic [XLEN-1:0]       dmem_rdata,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic                  fwd_valid,
    output logic                  load_err,
    output logic [31:0]           retired,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(LOAD_TIMEOUT + 1);

    state_t                  state;
    logic [REG_ADDR_W-1:0]   lat_rd;
    logic                    lat_rw;
    logic [1:0]              lat_off;
    logic [2:0]              lat_funct3;
    logic [CNT_W-1:0]        tmo_cnt;

    logic                    accept;
    logic                    load_ok;
    logic [7:0]              ld_byte;
    logic [15:0]             ld_half;
    logic [XLEN-1:0]         load_data;
    logic                    commit_go;
    logic                    commit_rw;
    logic [REG_ADDR_W-1:0]   commit_rd;
    logic [XLEN-1:0]         commit_data;
    logic                    commit_we;

    assign in_ready  = (state != S_WAIT);
    assign accept    = in_valid & in_ready;
    assign state_dbg = state;

    // Legal width code and natural alignment of the effective address.
    always_comb begin
        load_ok = 1'b0;
        case (in_funct3)
            3'b000, 3'b100: load_ok = 1'b1;
            3'b001, 3'b101: load_ok = ~in_result[0];
            3'b010:         load_ok = (in_result[1:0] == 2'b00);
            default:        load_ok = 1'b0;
        endcase
    end

    assign ld_byte = dmem_rdata[{lat_off, 3'b000} +: 8];
    assign ld_half = lat_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    // Select the byte/halfword at the latched offset and extend it.
    always_comb begin
        load_data = dmem_rdata;
        case (lat_funct3)
            3'b000:  load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001:  load_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, ld_half};
            default: load_data = dmem_rdata;
        endcase
    end

    // Which instruction (if any) enters WRITE at the next edge.
    always_comb begin
        commit_go   = 1'b0;
        commit_rw   = 1'b0;
        commit_rd   = '0;
        commit_data = '0;
        if (state == S_WAIT) begin
            if (dmem_rvalid) begin
                commit_go   = 1'b1;
                commit_rw   = lat_rw;
                commit_rd   = lat_rd;
                commit_data = load_data;
            end
        end else if (accept && !in_is_load) begin
            commit_go   = 1'b1;
            commit_rw   = in_reg_write;
            commit_rd   = in_rd;
            commit_data = in_result;
        end
    end

    // x0 is never written, but the instruction still retires.
    assign commit_we = commit_go & commit_rw & (commit_rd != '0);

    // Control FSM with registered write-port, error and retire outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            fwd_valid  <= 1'b0;
            load_err   <= 1'b0;
            retired    <= 32'd0;
            lat_rd     <= '0;
            lat_rw     <= 1'b0;
            lat_off    <= 2'b00;
            lat_funct3 <= 3'b000;
            tmo_cnt    <= '0;
        end else begin
            rf_we     <= commit_we;
            fwd_valid <= commit_we;
            load_err  <= 1'b0;
            if (commit_we) begin
                rf_waddr <= commit_rd;
                rf_wdata <= commit_data;
            end
            if (commit_go) begin
                retired <= retired + 32'd1;
            end

            case (state)
                S_IDLE, S_WRITE: begin
                    state <= S_IDLE;
                    if (accept) begin
                        if (!in_is_load) begin
                            state <= S_WRITE;
                        end else if (!load_ok) begin
                            load_err <= 1'b1;
                        end else begin
                            lat_rd     <= in_rd;
                            lat_rw     <= in_reg_write;
                            lat_off    <= in_result[1:0];
                            lat_funct3 <= in_funct3;
                            tmo_cnt    <= '0;
                            state      <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (dmem_rvalid) begin
                        state <= S_WRITE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (tmo_cnt == CNT_W'(LOAD_TIMEOUT - 1)) begin
                            load_err <= 1'b1;
                            state    <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios followed by a randomized mix of ALU
// ops and loads, checked against a transaction-level reference model.
module tb_wb_stage;

    localparam int XLEN = 32;
    localparam int RAW  = 5;
    localparam int TMO  = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            in_reg_write = 1'b0;
    logic            in_is_load = 1'b0;
    logic [RAW-1:0]  in_rd = '0;
    logic [XLEN-1:0] in_result = '0;
    logic [2:0]      in_funct3 = 3'b000;
    logic            dmem_rvalid = 1'b0;
    logic [XLEN-1:0] dmem_rdata = '0;
    logic            rf_we;
    logic [RAW-1:0]  rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            fwd_valid;
    logic            load_err;
    logic [31:0]     retired;
    logic [1:0]      state_dbg;

    wb_stage #(.XLEN(XLEN), .REG_ADDR_W(RAW), .LOAD_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_reg_write(in_reg_write), .in_is_load(in_is_load),
        .in_rd(in_rd), .in_result(in_result), .in_funct3(in_funct3),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_valid(fwd_valid), .load_err(load_err), .retired(retired),
        .state_dbg(state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // Scoreboard state
    int              checks = 0;
    int              failures = 0;
    logic [RAW+XLEN-1:0] exp_q[$];
    int unsigned     exp_ret = 0;
    logic [RAW-1:0]  pl_rd;
    logic            pl_rw;
    logic [31:0]     pl_addr;
    logic [2:0]      pl_f3;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: legality and load value from plain arithmetic.
    function automatic bit load_legal(input logic [2:0] f3, input logic [31:0] addr);
        case (f3)
            3'd0, 3'd4: return 1'b1;
            3'd1, 3'd5: return (addr % 2) == 0;
            3'd2:       return (addr % 4) == 0;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        int unsigned sh;
        logic [31:0] v;
        sh = 8 * (addr % 4);
        v  = rdata >> sh;
        case (f3)
            3'd0: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
            3'd4: v = v % 256;
            3'd1: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
            3'd5: v = v % 65536;
            default: v = rdata;
        endcase
        return v;
    endfunction

    // Drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic ld, input logic rw, input logic [RAW-1:0] rd,
                        input logic [31:0] res, input logic [2:0] f3);
        bit acc;
        bit legal;
        int waited;
        acc = 0;
        waited = 0;
        legal = load_legal(f3, res);
        in_valid = 1'b1; in_is_load = ld; in_reg_write = rw;
        in_rd = rd; in_result = res; in_funct3 = f3;
        if (!ld) begin
            if (rw && rd != 0) exp_q.push_back({rd, res});
            exp_ret++;
        end else if (legal) begin
            pl_rd = rd; pl_rw = rw; pl_addr = res; pl_f3 = f3;
        end
        while (!acc && waited < 50) begin
            acc = in_ready;
            tick();
            waited++;
        end
        in_valid = 1'b0;
        if (!acc) check("accept_timeout", 0, 1);
        if (!ld) begin
            check("alu_we", rf_we, (rw && rd != 0));
            check("alu_fwd", fwd_valid, (rw && rd != 0));
        end else if (!legal) begin
            check("bad_load_err", load_err, 1);
            check("bad_load_we", rf_we, 0);
            check("bad_load_ready", in_ready, 1);
        end else begin
            check("load_wait_ready", in_ready, 0);
            check("load_no_err", load_err, 0);
        end
    endtask

    task automatic respond(input logic [31:0] rdata);
        logic exp_we;
        exp_we = pl_rw && pl_rd != 0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        if (exp_we) exp_q.push_back({pl_rd, load_model(pl_f3, pl_addr, rdata)});
        exp_ret++;
        tick();
        dmem_rvalid = 1'b0;
        check("load_we", rf_we, exp_we);
        check("load_ready_after", in_ready, 1);
    endtask

    task automatic idle(input bit noise);
        in_valid = 1'b0;
        dmem_rvalid = noise;
        dmem_rdata = $urandom;
        tick();
        dmem_rvalid = 1'b0;
        check("idle_no_extra_we", rf_we, 0);
    endtask

    // Monitor: every register-file write must match the next expected one.
    always @(posedge clk) begin
        logic [RAW+XLEN-1:0] e;
        #2;
        if (rst && rf_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("wb_addr", rf_waddr, e[RAW+XLEN-1:XLEN]);
                check("wb_data", rf_wdata, e[XLEN-1:0]);
            end
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b0;
        repeat (3) tick();
        check("rst_we", rf_we, 0);
        check("rst_waddr", rf_waddr, 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_fwd", fwd_valid, 0);
        check("rst_err", load_err, 0);
        check("rst_retired", retired, 0);
        check("rst_state", state_dbg, 0);
        check("rst_ready", in_ready, 1);
        rst = 1'b1;
        tick();

        // Reset mid-WAIT aborts the load; a later response is discarded
        send(1'b0, 1'b1, 5'd3, 32'h11, 3'b000);
        send(1'b0, 1'b1, 5'd4, 32'h22, 3'b000);
        send(1'b1, 1'b1, 5'd8, 32'h200, 3'b010);
        tick();
        check("t1_in_wait", in_ready, 0);
        rst = 1'b0;
        #1;
        check("t1_rst_we", rf_we, 0);
        check("t1_rst_retired", retired, 0);
        check("t1_rst_state", state_dbg, 0);
        check("t1_rst_ready", in_ready, 1);
        check("t1_rst_wdata", rf_wdata, 0);
        tick();
        rst = 1'b1;
        exp_ret = 0;
        exp_q.delete();
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        tick();
        dmem_rvalid = 1'b0;
        check("t1_late_rvalid_we", rf_we, 0);
        check("t1_late_rvalid_ret", retired, 0);

        // Back-to-back ALU ops, including an rd=0 one
        send(1'b0, 1'b1, 5'd1, 32'hA, 3'b000);
        check("t2_waddr0", rf_waddr, 1);
        check("t2_wdata0", rf_wdata, 32'hA);
        send(1'b0, 1'b1, 5'd2, 32'hB, 3'b000);
        check("t2_waddr1", rf_waddr, 2);
        check("t2_wdata1", rf_wdata, 32'hB);
        send(1'b0, 1'b1, 5'd0, 32'hC, 3'b000);
        check("t2_we2", rf_we, 0);
        idle(0);
        check("t2_retired", retired, 3);

        // Sub-word loads with sign/zero extension
        send(1'b1, 1'b1, 5'd3, 32'h103, 3'b000);
        respond(32'h80FF1234);
        check("t3_lb", rf_wdata, 32'hFFFFFF80);
        send(1'b1, 1'b1, 5'd4, 32'h103, 3'b100);
        respond(32'h80FF1234);
        check("t3_lbu", rf_wdata, 32'h00000080);
        send(1'b1, 1'b1, 5'd7, 32'h102, 3'b001);
        respond(32'h80FF1234);
        check("t3_lh", rf_wdata, 32'hFFFF80FF);
        check("t3_lh_addr", rf_waddr, 7);
        idle(0);
        check("t3_retired", retired, 6);

        // Misaligned LW, then illegal funct3, back to back
        send(1'b1, 1'b1, 5'd9, 32'h2, 3'b010);
        send(1'b1, 1'b1, 5'd9, 32'h0, 3'b011);
        idle(0);
        check("t4_err_cleared", load_err, 0);
        check("t4_retired", retired, 6);

        // Timeout with no response, then a late response is ignored
        send(1'b1, 1'b1, 5'd10, 32'h10, 3'b010);
        for (int i = 1; i < TMO; i++) begin
            tick();
            check("t5_no_err_yet", load_err, 0);
            check("t5_still_wait", in_ready, 0);
        end
        tick();
        check("t5_timeout_err", load_err, 1);
        check("t5_timeout_ready", in_ready, 1);
        check("t5_timeout_we", rf_we, 0);
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'h5555AAAA;
        tick();
        dmem_rvalid = 1'b0;
        check("t5_late_we", rf_we, 0);
        check("t5_err_pulse", load_err, 0);
        check("t5_retired", retired, 6);

        // Load response coincides with a pending ALU op
        send(1'b1, 1'b1, 5'd5, 32'h40, 3'b010);
        tick();
        in_valid = 1'b1; in_is_load = 1'b0; in_reg_write = 1'b1;
        in_rd = 5'd6; in_result = 32'h66; in_funct3 = 3'b000;
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'h12345678;
        check("t6_ready_low", in_ready, 0);
        exp_q.push_back({5'd5, 32'h12345678});
        exp_q.push_back({5'd6, 32'h66});
        exp_ret += 2;
        tick();
        dmem_rvalid = 1'b0;
        check("t6_we_x5", rf_we, 1);
        check("t6_addr_x5", rf_waddr, 5);
        check("t6_ready_write", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("t6_we_x6", rf_we, 1);
        check("t6_addr_x6", rf_waddr, 6);
        check("t6_data_x6", rf_wdata, 32'h66);
        idle(0);
        check("t6_retired", retired, exp_ret);

        // Randomized mix against the reference model
        for (int n = 0; n < 300; n++) begin
            int k;
            logic [31:0] addr;
            logic [2:0] f3;
            k = $urandom_range(0, 9);
            if (k <= 4) begin
                send(1'b0, ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom, 3'b000);
            end else if (k <= 8) begin
                addr = $urandom;
                f3 = 3'($urandom_range(0, 7));
                send(1'b1, ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), addr, f3);
                if (load_legal(f3, addr)) begin
                    repeat ($urandom_range(0, 3)) begin
                        tick();
                        check("rnd_wait_ready", in_ready, 0);
                    end
                    respond($urandom);
                end
            end else begin
                idle($urandom_range(0, 3) == 0);
            end
        end
        idle(0);
        idle(0);
        check("final_retired", retired, exp_ret);
        check("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
